i2s_sample_feeder: RTL and testbench
====================================

// Module: i2s_sample_feeder
// PURPOSE
//  Upstream stage of the i2s transmitter. Buffers 16-bit audio samples from a producer in a
//  small FIFO and hands them one at a time to the transmitter on data/init. It paces each
//  transfer on the transmitter's busy flag, synchronised into main_clk.
//  It also flags underrun and handshake timeouts for the lock's audio path.
// PARAMETERS
//  DATA_W       16   sample width; matches transmitter data input
//  DEPTH        8    FIFO entries; power of two, >=2
//  INIT_HOLD    64   main_clk cycles init stays high; must exceed 2 bclk periods
//  BUSY_TMO     1024 main_clk cycles allowed for synced busy to rise after init falls
// PORTS
//  main_clk   in   1                 system clock; sole clock of this block
//  rst        in   1                 asynchronous reset, active-high
//  in_data    in   DATA_W            sample from producer
//  in_valid   in   1                 producer offers in_data
//  in_ready   out  1                 FIFO can accept; write occurs when in_valid & in_ready
//  play       in   1                 level; 1 = launch samples, 0 = hold FIFO contents
//  busy       in   1                 transmitter busy; asynchronous to main_clk (bclk domain)
//  data       out  DATA_W            sample to transmitter; stable from LOAD to IDLE return
//  init       out  1                 start request to transmitter
//  level      out  $clog2(DEPTH)+1   FIFO occupancy
//  underrun   out  1                 sticky; a frame ended with play=1 and FIFO empty
//  timeout    out  1                 sticky; busy never rose within BUSY_TMO
//  clr_flags  in   1                 synchronous clear of underrun and timeout
// BEHAVIOUR
//  Reset: all registered outputs are 0 (data, init, level, underrun, timeout). The FIFO is
//   emptied, the FSM goes to IDLE, and the synchroniser flops are cleared. in_ready=1 after reset.
//  Busy synchroniser:
//   - Two flops in main_clk give busy_s; all FSM decisions use busy_s only.
//  FIFO:
//   - in_ready = (level != DEPTH).
//   - A write and a pop in the same cycle leave level unchanged.
//   - A write when full is impossible because in_ready=0.
//   - Pointers wrap modulo DEPTH.
//  FSM:
//   - IDLE:
//     - If play=1, level>0 and busy_s=0: pop the head into data; go to LAUNCH next cycle.
//   - LAUNCH:
//     - init=1 for exactly INIT_HOLD cycles, counted from the LAUNCH entry; then go to WAIT_HI.
//   - WAIT_HI:
//     - init=0.
//     - busy_s=1: go to WAIT_LO.
//     - BUSY_TMO cycles pass without busy_s=1: set timeout and go to IDLE.
//   - WAIT_LO:
//     - busy_s=0: go to IDLE.
//     - If play=1 and level=0 in the cycle of that transition, set underrun.
//  Latency: pop to init rising edge is 1 cycle. Sample write to init is at least 2 cycles
//   (write, then IDLE pop).
//  Simultaneous events:
//   - A write into an empty FIFO is not visible to IDLE until the next cycle.
//   - clr_flags wins over a set in the same cycle.
//  play=0 mid-frame: the current frame completes normally; no new pop occurs. play is
//   ignored outside IDLE and the underrun check.
//  Reset mid-frame: init drops immediately, and the popped sample is discarded.
//  No combinational path from in_valid or busy to any output.
// TESTING
//  1. Write 0xA5A5, 0x1234 with play=1; model busy high 40 cycles after init falls, lasting 300
//     cycles -> data=0xA5A5, then 0x1234; init high exactly 64 cycles each; no flags set.
//  2. Write 8 samples with play=0 -> level=8, in_ready=0; a 9th in_valid is not accepted.
//     Set play=1 -> samples leave in order.
//  3. One sample, play=1; busy pulses once -> underrun=1 after busy falls.
//     Pulse clr_flags -> underrun=0.
//  4. Hold busy=0 permanently -> timeout=1 exactly 1024 cycles after init falls; FSM back in
//     IDLE; the next sample launches.
//  5. Write a sample and pop another in the same cycle at level=3 -> level stays 3.
//  6. Assert rst during LAUNCH -> init=0, level=0 and data=0 while rst is high; normal
//     operation resumes after release.

Source files
------------

// File: rtl/i2s_sample_feeder.sv
// i2s_sample_feeder: FIFO-buffered sample launcher for the i2s transmitter, paced on a synchronised busy flag
module i2s_sample_feeder #(
   parameter int DATA_W    = 16,
   parameter int DEPTH     = 8,
   parameter int INIT_HOLD = 64,
   parameter int BUSY_TMO  = 1024
) (
   input  logic                       main_clk,
   input  logic                       rst,
   input  logic [DATA_W-1:0]          in_data,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic                       play,
   input  logic                       busy,
   output logic [DATA_W-1:0]          data,
   output logic                       init,
   output logic [$clog2(DEPTH):0]     level,
   output logic                       underrun,
   output logic                       timeout,
   input  logic                       clr_flags
);
   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam int CW = $clog2((BUSY_TMO > INIT_HOLD ? BUSY_TMO : INIT_HOLD) + 1);
   typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_HI, WAIT_LO} state_t;
   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
   logic [LW-1:0]     level_q, level_d;
   logic [CW-1:0]     cnt_q;
   state_t            state_q;
   logic              busy_m_q, busy_s_q;
   logic [DATA_W-1:0] data_q;
   logic              init_q, underrun_q, timeout_q;
   logic              wr, pop, set_und, set_tmo;
   assign in_ready = level_q != LW'(DEPTH);
   assign wr       = in_valid & in_ready;
   assign pop      = (state_q == IDLE) & play & (level_q != '0) & ~busy_s_q;
   assign set_und  = (state_q == WAIT_LO) & ~busy_s_q & play & (level_q == '0);
   assign set_tmo  = (state_q == WAIT_HI) & ~busy_s_q & (cnt_q == CW'(BUSY_TMO - 1));
   assign level_d  = level_q + LW'(wr) - LW'(pop);
   assign data     = data_q;
   assign init     = init_q;
   assign level    = level_q;
   assign underrun = underrun_q;
   assign timeout  = timeout_q;
   always_ff @(posedge main_clk) begin
      if (wr) mem_q[wr_ptr_q] <= in_data;
   end
   always_ff @(posedge main_clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
         busy_m_q   <= 1'b0;
         busy_s_q   <= 1'b0;
         underrun_q <= 1'b0;
         timeout_q  <= 1'b0;
      end else begin
         wr_ptr_q   <= wr ? wr_ptr_q + AW'(1) : wr_ptr_q;
         rd_ptr_q   <= pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
         level_q    <= level_d;
         busy_m_q   <= busy;
         busy_s_q   <= busy_m_q;
         underrun_q <= clr_flags ? 1'b0 : (underrun_q | set_und);
         timeout_q  <= clr_flags ? 1'b0 : (timeout_q | set_tmo);
      end
   end
   // cnt_q times the init pulse in LAUNCH, then the busy wait in WAIT_HI
   always_ff @(posedge main_clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         data_q  <= '0;
         init_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: if (pop) begin
               data_q  <= mem_q[rd_ptr_q];
               init_q  <= 1'b1;
               cnt_q   <= '0;
               state_q <= LAUNCH;
            end
            LAUNCH: if (cnt_q == CW'(INIT_HOLD - 1)) begin
               init_q  <= 1'b0;
               cnt_q   <= '0;
               state_q <= WAIT_HI;
            end else begin
               cnt_q <= cnt_q + CW'(1);
            end
            WAIT_HI: if (busy_s_q) state_q <= WAIT_LO;
               else if (set_tmo) state_q <= IDLE;
               else cnt_q <= cnt_q + CW'(1);
            WAIT_LO: if (!busy_s_q) state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_i2s_sample_feeder.sv
// tb_i2s_sample_feeder: queue-based frame model checked every cycle, plus directed literal checks
module tb_i2s_sample_feeder;
   localparam int DEPTH = 8;
   localparam int INIT_HOLD = 64;
   localparam int BUSY_TMO = 1024;
   logic main_clk = 0, rst = 1;
   logic [15:0] in_data = '0;
   logic in_valid = 0, play = 0, busy = 0, clr_flags = 0;
   logic in_ready, init, underrun, timeout;
   logic [15:0] data;
   logic [3:0] level;
   int checks = 0, errors = 0;
   bit chk_en = 0;
   i2s_sample_feeder dut (
      .main_clk(main_clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
      .in_ready(in_ready), .play(play), .busy(busy), .data(data), .init(init),
      .level(level), .underrun(underrun), .timeout(timeout), .clr_flags(clr_flags)
   );
   always #5 main_clk = ~main_clk;
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask
   // model: FIFO as a queue, frame as init countdown then busy wait
   logic [15:0] mq [$];
   bit m_frame = 0, m_init = 0, m_seen = 0, m_und = 0, m_tmo = 0, bs1 = 0, bs2 = 0;
   logic [15:0] m_data = '0;
   int m_init_left = 0, m_hi_left = 0;
   int sz;
   bit bsv, su, st, mpop, mwr;
   always @(posedge main_clk or posedge rst) begin
      if (rst) begin
         mq.delete();
         m_frame = 0; m_init = 0; m_seen = 0; m_und = 0; m_tmo = 0; bs1 = 0; bs2 = 0;
         m_data = '0; m_init_left = 0; m_hi_left = 0;
      end else begin
         sz = mq.size();
         bsv = bs2;
         su = 0;
         st = 0;
         mpop = !m_frame && play && sz > 0 && !bsv;
         mwr = in_valid && sz < DEPTH;
         if (!m_frame) begin
            if (mpop) begin
               m_data = mq.pop_front();
               m_frame = 1; m_init = 1; m_init_left = INIT_HOLD;
            end
         end else if (m_init_left > 0) begin
            m_init_left--;
            if (m_init_left == 0) begin
               m_init = 0; m_hi_left = BUSY_TMO; m_seen = 0;
            end
         end else if (!m_seen) begin
            if (bsv) m_seen = 1;
            else begin
               m_hi_left--;
               if (m_hi_left == 0) begin st = 1; m_frame = 0; end
            end
         end else if (!bsv) begin
            m_frame = 0;
            su = play && sz == 0;
         end
         if (mwr) mq.push_back(in_data);
         m_und = clr_flags ? 0 : (m_und | su);
         m_tmo = clr_flags ? 0 : (m_tmo | st);
         bs2 = bs1;
         bs1 = busy;
      end
   end
   always @(negedge main_clk) if (chk_en) begin
      chk("data", data, m_data);
      chk("init", init, m_init);
      chk("level", level, mq.size());
      chk("in_ready", in_ready, mq.size() != DEPTH);
      chk("underrun", underrun, m_und);
      chk("timeout", timeout, m_tmo);
   end
   // transmitter stand-in: busy pulse a fixed delay after init falls
   bit busy_mode = 0, init_was = 0;
   int busy_dly = 40, busy_len = 300, bcnt = -1;
   initial forever begin
      @(posedge main_clk); #2;
      if (busy_mode && init_was && !init) bcnt = 0;
      else if (bcnt >= 0) bcnt++;
      busy = busy_mode && bcnt >= busy_dly && bcnt < busy_dly + busy_len;
      if (bcnt >= busy_dly + busy_len) bcnt = -1;
      init_was = init;
   end
   task automatic tick();
      @(posedge main_clk); #2;
   endtask
   task automatic push(input logic [15:0] d);
      in_data = d; in_valid = 1; tick(); in_valid = 0;
   endtask
   task automatic wait_init(input logic val, input int max, output int n);
      n = 0;
      while (init !== val && n < max) begin tick(); n++; end
      if (init !== val) begin
         checks++; errors++;
         $display("FAIL wait_init got %0b expected %0b within %0d cycles", init, val, max);
      end
   endtask
   task automatic wait_idle(input int max);
      int n = 0;
      while ((m_frame || mq.size() != 0) && n < max) begin tick(); n++; end
      if (m_frame || mq.size() != 0) begin
         checks++; errors++;
         $display("FAIL wait_idle frame still active after %0d cycles", max);
      end
   endtask
   task automatic clear();
      clr_flags = 1; tick(); clr_flags = 0;
   endtask
   int n;
   initial begin
      repeat (3) tick();
      chk_en = 1;
      tick();
      chk("rst_data", data, 0);
      chk("rst_init", init, 0);
      chk("rst_level", level, 0);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_flags", {underrun, timeout}, 0);
      rst = 0;
      tick();
      // two samples, busy 40 cycles after init falls for 300 cycles
      busy_mode = 1; busy_dly = 40; busy_len = 300;
      play = 1;
      push(16'hA5A5);
      push(16'h1234);
      wait_init(1, 10, n);
      chk("t1_data0", data, 16'hA5A5);
      n = 0;
      while (init === 1 && n < 200) begin n++; tick(); end
      chk("t1_init_len", n, 64);
      wait_init(1, 1000, n);
      chk("t1_data1", data, 16'h1234);
      play = 0;
      wait_idle(1000);
      chk("t1_flags", {underrun, timeout}, 0);
      // fill to full, refuse a ninth, then drain in order
      busy_dly = 2; busy_len = 5;
      for (int i = 0; i < 8; i++) push(16'h0100 + 16'(i));
      chk("t2_level_full", level, 8);
      chk("t2_in_ready", in_ready, 0);
      push(16'hDEAD);
      chk("t2_level_9th", level, 8);
      play = 1;
      wait_init(1, 10, n);
      chk("t2_first", data, 16'h0100);
      wait_idle(2000);
      chk("t2_last", data, 16'h0107);
      chk("t2_underrun", underrun, 1);
      clear();
      // single sample ending with empty FIFO
      push(16'h3333);
      wait_idle(500);
      chk("t3_underrun", underrun, 1);
      clear();
      chk("t3_cleared", underrun, 0);
      // simultaneous write and pop at level 3
      play = 0;
      push(16'h0A01); push(16'h0A02); push(16'h0A03);
      chk("t5_level3", level, 3);
      play = 1; in_data = 16'h0A04; in_valid = 1;
      tick();
      in_valid = 0;
      chk("t5_level_hold", level, 3);
      chk("t5_init", init, 1);
      chk("t5_data", data, 16'h0A01);
      wait_idle(3000);
      clear();
      // busy never rises
      busy_mode = 0;
      push(16'h4444);
      wait_init(1, 10, n);
      wait_init(0, 200, n);
      n = 0;
      while (timeout !== 1 && n < 2000) begin tick(); n++; end
      chk("t4_tmo_delay", n, 1024);
      chk("t4_init_low", init, 0);
      push(16'h5555);
      wait_init(1, 10, n);
      chk("t4_relaunch_lat", n, 1);
      chk("t4_relaunch", data, 16'h5555);
      wait_idle(3000);
      clear();
      chk("t4_cleared", timeout, 0);
      // reset in the middle of LAUNCH
      busy_mode = 1; busy_dly = 2; busy_len = 5;
      play = 0;
      push(16'h6001); push(16'h6002);
      play = 1;
      wait_init(1, 10, n);
      repeat (3) tick();
      rst = 1;
      #1;
      chk("t6_init", init, 0);
      chk("t6_level", level, 0);
      chk("t6_data", data, 0);
      tick(); tick();
      rst = 0;
      tick();
      push(16'h6003);
      wait_init(1, 20, n);
      chk("t6_resume", data, 16'h6003);
      wait_idle(500);
      chk_en = 0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
